// File: rtl/cv32e40p_ft_error_monitor.sv
// Per-lane TMR voter error monitor: saturating corrected-error totals, a leaky bucket per lane
// to separate transient upsets from permanent replica faults, a sticky fatal flag and a new-fault irq.
module cv32e40p_ft_error_monitor #(
    parameter int N_UNITS = 4,
    parameter int CNT_W   = 8,
    parameter int THRESH  = 4,
    parameter int WINDOW  = 1024
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [N_UNITS-1:0]         valid_i,
    input  logic [N_UNITS-1:0]         error_correct_i,
    input  logic [N_UNITS-1:0]         error_detected_i,
    input  logic                       clear_i,
    input  logic [$clog2(N_UNITS)-1:0] rd_sel_i,
    output logic [CNT_W-1:0]           rd_count_o,
    output logic [N_UNITS-1:0]         perm_fault_o,
    output logic                       fatal_o,
    output logic                       irq_o
);

    localparam int WIN_W = $clog2(WINDOW);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] THR      = CNT_W'(THRESH);
    localparam logic [WIN_W-1:0] WIN_LAST = WIN_W'(WINDOW - 1);
    localparam logic [WIN_W-1:0] WIN_ONE  = WIN_W'(1);

    logic [CNT_W-1:0]   tot_q [N_UNITS];
    logic [CNT_W-1:0]   tot_d [N_UNITS];
    logic [CNT_W-1:0]   bkt_q [N_UNITS];
    logic [CNT_W-1:0]   bkt_d [N_UNITS];
    logic [WIN_W-1:0]   win_q, win_d;
    logic [N_UNITS-1:0] corr_ev, det_ev;
    logic [N_UNITS-1:0] perm_q, perm_d;
    logic               fatal_q, fatal_d;
    logic               irq_q, irq_d;
    logic               leak;

    always_comb begin
        leak    = (win_q == WIN_LAST);
        win_d   = leak ? '0 : win_q + WIN_ONE;
        corr_ev = valid_i & error_correct_i & ~error_detected_i;
        det_ev  = valid_i & error_detected_i;
        perm_d  = perm_q;
        for (int u = 0; u < N_UNITS; u++) begin
            tot_d[u] = tot_q[u];
            bkt_d[u] = bkt_q[u];
            if (corr_ev[u] && tot_q[u] != CNT_MAX) begin
                tot_d[u] = tot_q[u] + CNT_ONE;
            end
            // A correction coinciding with a leak cancels out and leaves the bucket unchanged.
            if (corr_ev[u] && !leak && bkt_q[u] != CNT_MAX) begin
                bkt_d[u] = bkt_q[u] + CNT_ONE;
            end else if (!corr_ev[u] && leak && bkt_q[u] != '0) begin
                bkt_d[u] = bkt_q[u] - CNT_ONE;
            end
            if (bkt_d[u] >= THR) begin
                perm_d[u] = 1'b1;
            end
        end
        fatal_d = fatal_q | (|det_ev);
        irq_d   = (|(perm_d & ~perm_q)) | (fatal_d & ~fatal_q);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int u = 0; u < N_UNITS; u++) begin
                tot_q[u] <= '0;
                bkt_q[u] <= '0;
            end
            win_q   <= '0;
            perm_q  <= '0;
            fatal_q <= 1'b0;
            irq_q   <= 1'b0;
        end else if (clear_i) begin
            for (int u = 0; u < N_UNITS; u++) begin
                tot_q[u] <= '0;
                bkt_q[u] <= '0;
            end
            win_q   <= '0;
            perm_q  <= '0;
            fatal_q <= 1'b0;
            irq_q   <= 1'b0;
        end else begin
            for (int u = 0; u < N_UNITS; u++) begin
                tot_q[u] <= tot_d[u];
                bkt_q[u] <= bkt_d[u];
            end
            win_q   <= win_d;
            perm_q  <= perm_d;
            fatal_q <= fatal_d;
            irq_q   <= irq_d;
        end
    end

    // Selects beyond the last lane read as zero.
    always_comb begin
        rd_count_o = '0;
        if (32'(rd_sel_i) < N_UNITS) begin
            rd_count_o = tot_q[rd_sel_i];
        end
    end

    assign perm_fault_o = perm_q;
    assign fatal_o      = fatal_q;
    assign irq_o        = irq_q;

endmodule

// File: tb/tb_cv32e40p_ft_error_monitor.sv
// Bench for cv32e40p_ft_error_monitor: directed scenarios plus random traffic, checked against
// a cycle-level reference model built from per-lane integer counters.
module tb_cv32e40p_ft_error_monitor;

    localparam int N    = 5;
    localparam int CW   = 3;
    localparam int TH   = 4;
    localparam int WIN  = 16;
    localparam int SW   = $clog2(N);
    localparam int MAXC = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          rst;
    logic [N-1:0]  valid, corr, det;
    logic          clear;
    logic [SW-1:0] rd_sel;
    logic [CW-1:0] rd_count;
    logic [N-1:0]  perm_fault;
    logic          fatal, irq;

    cv32e40p_ft_error_monitor #(
        .N_UNITS(N), .CNT_W(CW), .THRESH(TH), .WINDOW(WIN)
    ) dut (
        .clk(clk), .rst(rst),
        .valid_i(valid), .error_correct_i(corr), .error_detected_i(det),
        .clear_i(clear), .rd_sel_i(rd_sel),
        .rd_count_o(rd_count), .perm_fault_o(perm_fault), .fatal_o(fatal), .irq_o(irq)
    );

    always #5 clk = ~clk;

    int         m_tot [N];
    int         m_bkt [N];
    logic [N-1:0] m_perm;
    logic       m_fatal, m_irq;
    int         m_cyc;
    int         n_pass = 0;
    int         n_total = 0;

    task automatic model_reset();
        for (int u = 0; u < N; u++) begin
            m_tot[u] = 0;
            m_bkt[u] = 0;
        end
        m_perm = '0; m_fatal = 1'b0; m_irq = 1'b0; m_cyc = 0;
    endtask

    // One clock edge of the reference, using the inputs as they were at that edge.
    task automatic model_step();
        bit is_leak, newf, any_det, ce, de;
        if (clear) begin
            model_reset();
            return;
        end
        is_leak = ((m_cyc % WIN) == WIN - 1);
        m_cyc++;
        newf = 0; any_det = 0;
        for (int u = 0; u < N; u++) begin
            ce = valid[u] && corr[u] && !det[u];
            de = valid[u] && det[u];
            if (ce) m_tot[u] = (m_tot[u] + 1 > MAXC) ? MAXC : m_tot[u] + 1;
            if (ce && !is_leak) m_bkt[u] = (m_bkt[u] + 1 > MAXC) ? MAXC : m_bkt[u] + 1;
            else if (!ce && is_leak) m_bkt[u] = (m_bkt[u] > 0) ? m_bkt[u] - 1 : 0;
            if (m_bkt[u] >= TH && !m_perm[u]) begin
                m_perm[u] = 1'b1;
                newf = 1;
            end
            if (de) any_det = 1;
        end
        if (any_det && !m_fatal) begin
            m_fatal = 1'b1;
            newf = 1;
        end
        m_irq = newf;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic check_all(input string tag);
        int exp_cnt;
        exp_cnt = (int'(rd_sel) < N) ? m_tot[rd_sel] : 0;
        check({tag, ".rd_count"}, 32'(rd_count), 32'(exp_cnt));
        check({tag, ".perm"}, 32'(perm_fault), 32'(m_perm));
        check({tag, ".fatal"}, 32'(fatal), 32'(m_fatal));
        check({tag, ".irq"}, 32'(irq), 32'(m_irq));
    endtask

    // Drive one cycle of inputs (from a negedge), clock it, then compare at the next negedge.
    task automatic cyc(input string tag, input logic [N-1:0] v, input logic [N-1:0] c,
                       input logic [N-1:0] d, input logic clr);
        valid = v; corr = c; det = d; clear = clr;
        @(posedge clk);
        model_step();
        @(negedge clk);
        valid = '0; corr = '0; det = '0; clear = 1'b0;
        check_all(tag);
    endtask

    task automatic idle(input string tag, input int n);
        for (int i = 0; i < n; i++) cyc(tag, '0, '0, '0, 1'b0);
    endtask

    initial begin
        logic [N-1:0] rv, rc, rd;
        rst = 1'b1; valid = '0; corr = '0; det = '0; clear = 1'b0; rd_sel = '0;
        model_reset();
        repeat (2) @(negedge clk);
        check_all("reset");
        rst = 1'b0;

        // Build up lane 1 state, then hit it with an asynchronous reset mid-cycle.
        rd_sel = SW'(1);
        for (int i = 0; i < 4; i++) cyc("pre_rst", 5'b00010, 5'b00010, '0, 1'b0);
        check("pre_rst.perm1", 32'(perm_fault[1]), 32'd1);
        check("pre_rst.cnt", 32'(rd_count), 32'd4);
        #2 rst = 1'b1;
        #1;
        check("async_rst.rd_count", 32'(rd_count), 32'd0);
        check("async_rst.perm", 32'(perm_fault), 32'd0);
        check("async_rst.fatal", 32'(fatal), 32'd0);
        check("async_rst.irq", 32'(irq), 32'd0);
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        check_all("post_rst");

        // Threshold: four back-to-back corrections on lane 2, well before the first leak.
        rd_sel = SW'(2);
        for (int i = 0; i < 4; i++) begin
            cyc("thresh", 5'b00100, 5'b00100, '0, 1'b0);
            check("thresh.count", 32'(rd_count), 32'(i + 1));
        end
        check("thresh.perm2", 32'(perm_fault[2]), 32'd1);
        check("thresh.irq", 32'(irq), 32'd1);
        idle("thresh_idle", 1);
        check("thresh.irq_once", 32'(irq), 32'd0);
        idle("thresh_leak", 3 * WIN);
        check("thresh.sticky", 32'(perm_fault[2]), 32'd1);

        // Leak balance: corrections exactly on the leak cycle never grow the bucket.
        cyc("clr_a", '0, '0, '0, 1'b1);
        rd_sel = SW'(0);
        for (int i = 0; i < 4 * WIN; i++)
            cyc("leak_on", 5'b00001, ((i % WIN) == WIN - 1) ? 5'b00001 : 5'b00000, '0, 1'b0);
        check("leak_on.perm0", 32'(perm_fault[0]), 32'd0);
        check("leak_on.tot0", 32'(rd_count), 32'd4);
        cyc("clr_b", '0, '0, '0, 1'b1);
        for (int i = 0; i < 4 * WIN; i++)
            cyc("leak_off", 5'b00001, ((i % WIN) == WIN - 2) ? 5'b00001 : 5'b00000, '0, 1'b0);
        check("leak_off.perm0", 32'(perm_fault[0]), 32'd0);

        // Priority and gating on lane 3.
        cyc("clr_c", '0, '0, '0, 1'b1);
        rd_sel = SW'(3);
        cyc("both", 5'b01000, 5'b01000, 5'b01000, 1'b0);
        check("both.fatal", 32'(fatal), 32'd1);
        check("both.tot3", 32'(rd_count), 32'd0);
        check("both.irq", 32'(irq), 32'd1);
        cyc("gated", 5'b00000, 5'b01000, 5'b00000, 1'b0);
        check("gated.tot3", 32'(rd_count), 32'd0);
        cyc("det2", 5'b00001, 5'b00000, 5'b00001, 1'b0);
        check("det2.irq", 32'(irq), 32'd0);

        // Saturation of the total counter on lane 1.
        cyc("clr_d", '0, '0, '0, 1'b1);
        rd_sel = SW'(1);
        for (int i = 0; i < 10; i++) cyc("sat", 5'b00010, 5'b00010, '0, 1'b0);
        check("sat.count", 32'(rd_count), 32'(MAXC));

        // Clear wins over events arriving in the same cycle.
        cyc("clr_prio", 5'b00011, 5'b00001, 5'b00010, 1'b1);
        check("clr_prio.perm", 32'(perm_fault), 32'd0);
        check("clr_prio.fatal", 32'(fatal), 32'd0);
        check("clr_prio.irq", 32'(irq), 32'd0);

        // Random traffic, with occasional detections and clears.
        for (int i = 0; i < 400; i++) begin
            rv = N'($urandom);
            rc = N'($urandom);
            rd = ($urandom_range(0, 31) == 0) ? N'($urandom) : '0;
            rd_sel = SW'($urandom_range(0, (1 << SW) - 1));
            cyc("rand", rv, rc, rd, $urandom_range(0, 99) == 0);
        end

        // Readback sweep including selects beyond the last lane.
        for (int s = 0; s < (1 << SW); s++) begin
            rd_sel = SW'(s);
            #1;
            check("sweep.rd_count", 32'(rd_count), 32'((s < N) ? m_tot[s] : 0));
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
